// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared constants, types and helpers for the tick scheduler
package tick_sched_pkg;

    localparam int CH_SCAN   = 0;
    localparam int CH_DEB    = 1;
    localparam int CH_SLOW   = 2;
    localparam int CH_USER   = 3;
    localparam int NCH       = 4;
    // Widest divide value a config request can carry
    localparam int CFG_DIV_W = 16;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_BUSY  = 1'b1
    } cfg_state_t;

    typedef struct packed {
        logic [1:0]           ch;
        logic [CFG_DIV_W-1:0] div;
        logic                 en;
    } cfg_req_t;

    function automatic int pre_width(input int pre_div);
        return (pre_div <= 2) ? 1 : $clog2(pre_div);
    endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - config write handshake between control logic and the scheduler
interface tick_scheduler_if #(
    parameter int DIV_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one programmable divider channel clocked by the shared prescaler strobe
module tick_channel #(
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_term,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    input  logic             load_en,
    output logic             tick
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic             en;

    // A load always wins over a terminal count so the new ratio restarts cleanly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div  <= DIV_W'(DIV_RST);
            en   <= 1'b1;
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (load) begin
                div <= load_div;
                en  <= load_en;
                cnt <= '0;
            end else if (!en) begin
                cnt <= '0;
            end else if (pre_term && (div != '0)) begin
                if (cnt >= div - DIV_W'(1)) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - prescaler, config handshake and scan select around four divider channels
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int PRE_DIV = 40,
    parameter int DIV_W   = 16,
    parameter int DIV0    = 1000,
    parameter int DIV1    = 6667,
    parameter int DIV2    = 40000,
    parameter int DIV3    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tick_scheduler_if.slave      cfg,
    output logic [NCH-1:0]       tick,
    output logic                 base_tick,
    output logic [1:0]           scan_sel
);

    localparam int PRE_W = pre_width(PRE_DIV);

    logic [PRE_W-1:0] pre_cnt;
    logic             pre_term;
    cfg_state_t       state;
    cfg_state_t       state_nxt;
    cfg_req_t         req;
    logic             accept;
    logic [NCH-1:0]   load;

    assign pre_term = (pre_cnt == PRE_W'(PRE_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            base_tick <= 1'b0;
        end else begin
            pre_cnt   <= pre_term ? '0 : pre_cnt + PRE_W'(1);
            base_tick <= pre_term;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_READY;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready drops for one cycle after each accepted write
    always_comb begin
        state_nxt     = state;
        cfg.cfg_ready = 1'b0;
        case (state)
            ST_READY: begin
                cfg.cfg_ready = 1'b1;
                if (cfg.cfg_valid) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY:  state_nxt = ST_READY;
            default:  state_nxt = ST_READY;
        endcase
    end

    assign accept  = cfg.cfg_valid && cfg.cfg_ready;
    assign req.ch  = cfg.cfg_ch;
    assign req.div = CFG_DIV_W'(cfg.cfg_div);
    assign req.en  = cfg.cfg_en;

    always_comb begin
        load = '0;
        if (accept) begin
            load[req.ch] = 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tick_channel #(
            .DIV_W   (DIV_W),
            .DIV_RST ((g == CH_SCAN) ? DIV0 :
                      (g == CH_DEB)  ? DIV1 :
                      (g == CH_SLOW) ? DIV2 : DIV3)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .pre_term (pre_term),
            .load     (load[g]),
            .load_div (DIV_W'(req.div)),
            .load_en  (req.en),
            .tick     (tick[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_sel <= 2'd0;
        end else if (tick[CH_SCAN] && (CH_USER == NCH - 1)) begin
            scan_sel <= scan_sel + 2'd1;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - self-checking bench for tick_scheduler
module tb_tick_scheduler;

    localparam int PRE_DIV = 4;
    localparam int RST_DIV [4] = '{3, 6, 5, 3};

    typedef struct {
        logic [3:0] tick;
        logic       base;
        logic [1:0] scan;
        logic       ready;
    } exp_t;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] div;
        logic        en;
        int          period;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tick;
    logic       base_tick;
    logic [1:0] scan_sel;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_no  = 0;
    exp_t sb_q[$];

    tick_scheduler_if #(.DIV_W(16)) cfg_if ();

    tick_scheduler #(
        .PRE_DIV (PRE_DIV),
        .DIV_W   (16),
        .DIV0    (3),
        .DIV1    (6),
        .DIV2    (5),
        .DIV3    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (cfg_if),
        .tick      (tick),
        .base_tick (base_tick),
        .scan_sel  (scan_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
        end
    endtask

    // Reference model: pushes the outputs expected after every posedge
    initial begin
        int         m_pre;
        int         m_cnt [4];
        int         m_div [4];
        bit         m_en  [4];
        bit         m_busy;
        logic [3:0] m_tick;
        logic [3:0] nt;
        logic       m_base;
        logic [1:0] m_scan;
        bit         pt;
        bit         acc;
        exp_t       e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_pre = 0; m_busy = 0; m_tick = '0; m_base = 0; m_scan = '0;
                for (int i = 0; i < 4; i++) begin
                    m_cnt[i] = 0; m_div[i] = RST_DIV[i]; m_en[i] = 1;
                end
            end else begin
                pt  = (m_pre == PRE_DIV - 1);
                acc = cfg_if.cfg_valid && !m_busy;
                nt  = '0;
                for (int i = 0; i < 4; i++) begin
                    if (acc && (int'(cfg_if.cfg_ch) == i)) begin
                        m_div[i] = int'(cfg_if.cfg_div);
                        m_en[i]  = cfg_if.cfg_en;
                        m_cnt[i] = 0;
                    end else if (!m_en[i]) begin
                        m_cnt[i] = 0;
                    end else if (pt && m_div[i] != 0) begin
                        if (m_cnt[i] + 1 >= m_div[i]) begin
                            m_cnt[i] = 0;
                            nt[i] = 1'b1;
                        end else begin
                            m_cnt[i]++;
                        end
                    end
                end
                if (m_tick[0]) m_scan = m_scan + 2'd1;
                m_tick = nt;
                m_base = pt;
                m_pre  = pt ? 0 : m_pre + 1;
                m_busy = acc;
            end
            e.tick = m_tick; e.base = m_base; e.scan = m_scan; e.ready = !m_busy;
            sb_q.push_back(e);
            edge_no = rst_n ? edge_no + 1 : 0;
        end
    end

    initial begin
        exp_t got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                got = sb_q.pop_front();
                check("sb_tick", tick, got.tick);
                check("sb_base_tick", base_tick, got.base);
                check("sb_scan_sel", scan_sel, got.scan);
                check("sb_cfg_ready", cfg_if.cfg_ready, got.ready);
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the accept edge
    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] div, input logic en);
        int guard = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_div   = div;
        cfg_if.cfg_en    = en;
        while (!cfg_if.cfg_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("cfg_write_timeout", guard < 10, 1);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick[ch] && n < limit);
        if (!tick[ch]) n = -1;
    endtask

    initial begin
        vec_t vecs [6];
        int   n1, n2, cnt, mism;
        int   first_base, first_t0, first_scan, scan48, scan49, a;
        int   first_t [4];

        vecs[0] = '{ch: 2'd3, div: 16'd2, en: 1'b1, period: 8};
        vecs[1] = '{ch: 2'd1, div: 16'd9, en: 1'b0, period: 0};
        vecs[2] = '{ch: 2'd1, div: 16'd5, en: 1'b1, period: 20};
        vecs[3] = '{ch: 2'd2, div: 16'd3, en: 1'b1, period: 12};
        vecs[4] = '{ch: 2'd2, div: 16'd0, en: 1'b1, period: 0};
        vecs[5] = '{ch: 2'd3, div: 16'd4, en: 1'b1, period: 16};

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_en    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tick", tick, 0);
        check("reset_base_tick", base_tick, 0);
        check("reset_scan_sel", scan_sel, 0);
        check("reset_cfg_ready", cfg_if.cfg_ready, 1);
        rst_n = 1'b1;

        first_base = -1; first_t0 = -1; first_scan = -1; scan48 = -1; scan49 = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (base_tick && first_base < 0) first_base = edge_no;
            if (tick[0] && first_t0 < 0) first_t0 = edge_no;
            if (scan_sel != 0 && first_scan < 0) first_scan = edge_no;
            if (edge_no == 48) scan48 = scan_sel;
            if (edge_no == 49) scan49 = scan_sel;
        end
        check("first_base_tick_edge", first_base, 4);
        check("first_scan_tick_edge", first_t0, 12);
        check("first_scan_sel_edge", first_scan, 13);
        check("scan_sel_before_wrap", scan48, 3);
        check("scan_sel_wrap", scan49, 0);

        foreach (vecs[i]) begin
            cfg_write(vecs[i].ch, vecs[i].div, vecs[i].en);
            check("vec_ready_drop", cfg_if.cfg_ready, 0);
            if (vecs[i].period == 0) begin
                cnt = 0;
                repeat (64) begin
                    @(negedge clk);
                    if (tick[vecs[i].ch]) cnt++;
                end
                check("vec_silent", cnt, 0);
            end else begin
                wait_tick(vecs[i].ch, 200, n1);
                check("vec_first_tick_seen", n1 > 0, 1);
                wait_tick(vecs[i].ch, 200, n2);
                check("vec_period", n2, vecs[i].period);
            end
        end

        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 16'd9; cfg_if.cfg_en = 1'b0;
        check("b2b_ready_first", cfg_if.cfg_ready, 1);
        a = edge_no;
        @(negedge clk);
        check("b2b_ready_low", cfg_if.cfg_ready, 0);
        cfg_if.cfg_div = 16'd5; cfg_if.cfg_en = 1'b1;
        cnt = tick[1];
        @(negedge clk);
        check("b2b_ready_back", cfg_if.cfg_ready, 1);
        cnt += tick[1];
        @(negedge clk);
        check("b2b_second_accept", cfg_if.cfg_ready, 0);
        check("b2b_second_accept_edge", edge_no - a, 3);
        cnt += tick[1];
        cfg_if.cfg_valid = 1'b0;
        check("b2b_silent_disabled", cnt, 0);
        wait_tick(1, 200, n1);
        wait_tick(1, 200, n2);
        check("b2b_period", n2, 20);

        wait_tick(0, 200, n1);
        check("collide_sync_tick", n1 > 0, 1);
        repeat (11) @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 16'd7; cfg_if.cfg_en = 1'b1;
        check("collide_ready", cfg_if.cfg_ready, 1);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        check("collide_no_tick", tick[0], 0);
        wait_tick(0, 200, n1);
        check("collide_next_tick", n1, 28);

        cfg_write(2'd2, 16'd1, 1'b1);
        mism = 0; cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (tick[2] !== base_tick) mism++;
            if (tick[2]) cnt++;
        end
        check("div1_matches_base", mism, 0);
        check("div1_tick_count", cnt, 10);

        repeat (5) @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 2'd3; cfg_if.cfg_div = 16'd9; cfg_if.cfg_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tick", tick, 0);
        check("midrst_base_tick", base_tick, 0);
        check("midrst_scan_sel", scan_sel, 0);
        check("midrst_cfg_ready", cfg_if.cfg_ready, 1);
        cfg_if.cfg_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) first_t[i] = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (tick[i] && first_t[i] < 0) first_t[i] = edge_no;
        end
        check("midrst_first_tick0", first_t[0], 12);
        check("midrst_first_tick1", first_t[1], 24);
        check("midrst_first_tick2", first_t[2], 20);
        check("midrst_first_tick3", first_t[3], 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
